wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback end of the M/W pipeline register. Consumes the `_W` outputs of the memory/writeback buffer.
- Selects the writeback value and commits it to a 2^REGBITS x DBITS register file.
- Gives decode two read ports, with same-cycle write-through bypass.
- Drives a forwarding bus for the hazard unit.

Parameters:
- DBITS, 32, data/PC width
- REGBITS, 4, register index width (2^REGBITS registers)

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- noop_W  in  1  bubble marker from M/W buffer; 1 = no instruction
- incPC_W  in  DBITS  PC+4 of the instruction (link value)
- ALUresult_W  in  DBITS  ALU result
- MEMresult_W  in  DBITS  load data
- destIndex_W  in  REGBITS  destination register
- regFileMux_W  in  2  result select: 00 ALU, 01 MEM, 10 incPC, 11 reserved
- regWrtEn_W  in  1  register write request
- rdIndex1  in  REGBITS  decode read port 1 index
- rdIndex2  in  REGBITS  decode read port 2 index
- rdData1  out  DBITS  read port 1 data
- rdData2  out  DBITS  read port 2 data
- fwdValid_W  out  1  a register write commits this cycle
- fwdIndex_W  out  REGBITS  index being written
- fwdData_W  out  DBITS  value being written
- badMux_W  out  1  registered sticky error: reserved mux code seen with a write request

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Write data (combinational):
  - wbData = ALUresult_W / MEMresult_W / incPC_W for mux code 00 / 01 / 10.
  - For mux code 11, wbData = 0.
- Commit condition: commit = regWrtEn_W & ~noop_W & (regFileMux_W != 2'b11) & ~reset.
- Register write: on posedge with commit, regs[destIndex_W] <= wbData.
  - All indices, including 0, are general purpose and writable.
- Forward bus (combinational, zero latency):
  - fwdValid_W = commit.
  - fwdIndex_W = destIndex_W.
  - fwdData_W = wbData.
  - When fwdValid_W = 0, fwdIndex_W and fwdData_W are don't-care but must be driven (no X).
- Read ports (combinational):
  - rdDataN = wbData when commit & (rdIndexN == destIndex_W); otherwise rdDataN = regs[rdIndexN].
  - Write-first semantics: decode sees a same-cycle writeback value with no extra stall.
  - Both ports may address the same index; both return identical data.
- noop handling: noop_W = 1 suppresses the write and fwdValid_W regardless of regWrtEn_W. The inputs may be garbage during a bubble.
- Reserved mux code:
  - regWrtEn_W & ~noop_W & (regFileMux_W == 11) suppresses the write.
  - It sets badMux_W on the next posedge.
  - badMux_W stays 1 until reset.
- Reset (synchronous):
  - On posedge with reset = 1, all registers <= 0 and badMux_W <= 0.
  - Reset wins over a simultaneous commit; the write is dropped.
  - While reset is high, fwdValid_W = 0 and rdData bypass is disabled, so reads return register contents (0 after the first reset edge).
- Back-to-back writes to the same index: the last one wins, one value per cycle. A read in the cycle of the second write returns the second value via bypass.
- Latency:
  - Commit is visible in registered state one cycle after the edge.
  - It is visible on reads and the forward bus in the same cycle via bypass.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- When defined:
  - Adds output port retireCnt_W, DBITS wide.
  - The counter increments on each posedge where noop_W = 0 and reset = 0, whether or not the instruction writes a register.
  - It wraps from 2^DBITS-1 to 0 and resets to 0.
- When undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - mux select constants WB_SEL_ALU = 2'b00, WB_SEL_MEM = 2'b01, WB_SEL_PC = 2'b10, WB_SEL_RSVD = 2'b11
  - DBITS/REGBITS defaults
- One sub-module, regfile_2r1w: storage, synchronous reset clear, and the write-first bypass.
- wb_stage holds the result mux, commit logic, forward bus, badMux flag and the optional counter.

Test Plan:
- Reset for 2 cycles, then read indices 0..15 -> all rdData = 0, badMux_W = 0, fwdValid_W = 0.
- ALUresult_W = 999, regFileMux_W = 00, destIndex_W = 13, regWrtEn_W = 1, noop_W = 0, rdIndex1 = 13 in the same cycle:
  - same cycle: rdData1 = 999, fwdValid_W = 1, fwdIndex_W = 13, fwdData_W = 999
  - next cycle with regWrtEn_W = 0: rdData1 = 999
- MEMresult_W = 777 / mux 01 to index 14, then incPC_W = 1 / mux 10 to index 15:
  - reads return 777 and 1
  - with noop_W = 1 and the same inputs to index 14 = 5: rdData (index 14) stays 777, fwdValid_W = 0
- regFileMux_W = 11, regWrtEn_W = 1 to index 2:
  - register 2 unchanged (0), fwdValid_W = 0
  - badMux_W = 1 next cycle and holds for 3 idle cycles
  - reset clears it to 0
- Commit of 42 to index 3 in the same cycle as reset = 1 -> register 3 reads 0 after the reset is released.
- With WB_RETIRE_CNT_EN: 4 non-noop cycles plus 2 noop cycles after reset -> retireCnt_W = 4.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths and writeback result-select codes for the pipeline stages
package pipe_pkg;
  localparam int DBITS_DEFAULT = 32;
  localparam int REGBITS_DEFAULT = 4;
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC = 2'b10;
  localparam logic [1:0] WB_SEL_RSVD = 2'b11;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2^REGBITS x DBITS register file, 2 read / 1 write ports, write-first bypass
// Ports: clk, reset (sync, active-high clear), we/waddr/wdata write port,
//        raddr1/raddr2 -> rdata1/rdata2 combinational reads.
module regfile_2r1w
  import pipe_pkg::*;
#(
  parameter int DBITS = DBITS_DEFAULT,
  parameter int REGBITS = REGBITS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [REGBITS-1:0] waddr,
  input  logic [DBITS-1:0]   wdata,
  input  logic [REGBITS-1:0] raddr1,
  input  logic [REGBITS-1:0] raddr2,
  output logic [DBITS-1:0]   rdata1,
  output logic [DBITS-1:0]   rdata2
);
  logic [DBITS-1:0] regs_q [2**REGBITS];
  logic [DBITS-1:0] regs_d [2**REGBITS];
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end
  // Same-cycle write is returned to decode so it never stalls on writeback.
  always_comb begin
    rdata1 = (we && raddr1 == waddr) ? wdata : regs_q[raddr1];
    rdata2 = (we && raddr2 == waddr) ? wdata : regs_q[raddr2];
  end
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage - result mux, register commit, decode read ports, forward bus
// Ports: M/W buffer inputs (*_W), decode reads rdIndex1/2 -> rdData1/2,
//        forward bus fwdValid_W/fwdIndex_W/fwdData_W, sticky badMux_W error flag.
// Build option WB_RETIRE_CNT_EN adds retireCnt_W, a count of non-bubble cycles.
module wb_stage
  import pipe_pkg::*;
#(
  parameter int DBITS = DBITS_DEFAULT,
  parameter int REGBITS = REGBITS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               noop_W,
  input  logic [DBITS-1:0]   incPC_W,
  input  logic [DBITS-1:0]   ALUresult_W,
  input  logic [DBITS-1:0]   MEMresult_W,
  input  logic [REGBITS-1:0] destIndex_W,
  input  logic [1:0]         regFileMux_W,
  input  logic               regWrtEn_W,
  input  logic [REGBITS-1:0] rdIndex1,
  input  logic [REGBITS-1:0] rdIndex2,
  output logic [DBITS-1:0]   rdData1,
  output logic [DBITS-1:0]   rdData2,
  output logic               fwdValid_W,
  output logic [REGBITS-1:0] fwdIndex_W,
  output logic [DBITS-1:0]   fwdData_W,
`ifdef WB_RETIRE_CNT_EN
  output logic [DBITS-1:0]   retireCnt_W,
`endif
  output logic               badMux_W
);
  logic [DBITS-1:0] wb_data;
  logic commit, rsvd_wr, bad_d, bad_q;
  always_comb begin
    wb_data = (regFileMux_W == WB_SEL_ALU) ? ALUresult_W :
              (regFileMux_W == WB_SEL_MEM) ? MEMresult_W :
              (regFileMux_W == WB_SEL_PC)  ? incPC_W : '0;
    rsvd_wr = regWrtEn_W & ~noop_W & (regFileMux_W == WB_SEL_RSVD);
    // Reset masks the commit so it also disables bypass and the forward bus.
    commit = regWrtEn_W & ~noop_W & (regFileMux_W != WB_SEL_RSVD) & ~reset;
    bad_d = bad_q | rsvd_wr;
  end
  always_ff @(posedge clk) begin
    if (reset) bad_q <= 1'b0;
    else bad_q <= bad_d;
  end
  assign badMux_W = bad_q;
  assign fwdValid_W = commit;
  assign fwdIndex_W = destIndex_W;
  assign fwdData_W = wb_data;
  regfile_2r1w #(.DBITS(DBITS), .REGBITS(REGBITS)) u_rf (
    .clk(clk), .reset(reset), .we(commit), .waddr(destIndex_W), .wdata(wb_data),
    .raddr1(rdIndex1), .raddr2(rdIndex2), .rdata1(rdData1), .rdata2(rdData2)
  );
`ifdef WB_RETIRE_CNT_EN
  logic [DBITS-1:0] cnt_d, cnt_q;
  always_comb cnt_d = cnt_q + DBITS'(~noop_W);
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign retireCnt_W = cnt_q;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vector bench for wb_stage
module tb_wb_stage;
  logic clk = 1'b0, reset = 1'b1, noop_W = 1'b0, regWrtEn_W = 1'b0, fwdValid_W, badMux_W;
  logic [31:0] incPC_W = '0, ALUresult_W = '0, MEMresult_W = '0, rdData1, rdData2, fwdData_W;
  logic [3:0] destIndex_W = '0, rdIndex1 = '0, rdIndex2 = '0, fwdIndex_W;
  logic [1:0] regFileMux_W = '0;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retireCnt_W;
`endif
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  wb_stage dut (
    .clk(clk), .reset(reset), .noop_W(noop_W), .incPC_W(incPC_W), .ALUresult_W(ALUresult_W),
    .MEMresult_W(MEMresult_W), .destIndex_W(destIndex_W), .regFileMux_W(regFileMux_W),
    .regWrtEn_W(regWrtEn_W), .rdIndex1(rdIndex1), .rdIndex2(rdIndex2), .rdData1(rdData1),
    .rdData2(rdData2), .fwdValid_W(fwdValid_W), .fwdIndex_W(fwdIndex_W), .fwdData_W(fwdData_W),
`ifdef WB_RETIRE_CNT_EN
    .retireCnt_W(retireCnt_W),
`endif
    .badMux_W(badMux_W)
  );
  typedef struct {
    logic rst, noop, wen;
    logic [1:0] mux;
    logic [3:0] dest, rd1, rd2;
    logic [31:0] inc, alu, mem;
    logic [31:0] e_rd1, e_rd2;
    logic e_fv, e_bad;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
  endtask
  task automatic add(input logic rst, input logic noop, input logic wen, input logic [1:0] mux,
                     input logic [3:0] dest, input logic [31:0] inc, input logic [31:0] alu,
                     input logic [31:0] mem, input logic [3:0] rd1, input logic [3:0] rd2,
                     input logic [31:0] e_rd1, input logic [31:0] e_rd2, input logic e_fv,
                     input logic e_bad);
    vec_t v;
    v.rst = rst; v.noop = noop; v.wen = wen; v.mux = mux; v.dest = dest;
    v.inc = inc; v.alu = alu; v.mem = mem; v.rd1 = rd1; v.rd2 = rd2;
    v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_fv = e_fv; v.e_bad = e_bad;
    vecs.push_back(v);
  endtask
  initial begin
    // rst noop wen mux dest inc alu mem rd1 rd2 | rd1 rd2 fv bad (sampled before the edge)
    add(0, 0, 1, 2'b00, 13, 0, 999, 0, 13, 0, 999, 0, 1, 0);
    add(0, 0, 0, 2'b00, 13, 0, 0, 0, 13, 13, 999, 999, 0, 0);
    add(0, 0, 1, 2'b01, 14, 0, 0, 777, 14, 13, 777, 999, 1, 0);
    add(0, 0, 1, 2'b10, 15, 1, 0, 0, 15, 14, 1, 777, 1, 0);
    add(0, 1, 1, 2'b01, 14, 0, 0, 5, 14, 15, 777, 1, 0, 0);
    add(0, 0, 1, 2'b11, 2, 0, 55, 0, 2, 14, 0, 777, 0, 0);
    add(0, 0, 0, 2'b00, 2, 0, 0, 0, 2, 3, 0, 0, 0, 1);
    add(0, 0, 0, 2'b00, 0, 0, 0, 0, 2, 14, 0, 777, 0, 1);
    add(0, 0, 0, 2'b00, 0, 0, 0, 0, 2, 13, 0, 999, 0, 1);
    add(0, 0, 0, 2'b00, 0, 0, 0, 0, 2, 15, 0, 1, 0, 1);
    add(0, 0, 1, 2'b00, 5, 0, 10, 0, 5, 4, 10, 0, 1, 1);
    add(0, 0, 1, 2'b00, 5, 0, 20, 0, 5, 5, 20, 20, 1, 1);
    add(0, 0, 0, 2'b00, 5, 0, 0, 0, 5, 13, 20, 999, 0, 1);
    add(0, 0, 1, 2'b00, 0, 0, 7, 0, 0, 13, 7, 999, 1, 1);
    add(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 15, 7, 1, 0, 1);
    add(1, 0, 1, 2'b00, 3, 0, 42, 0, 3, 5, 0, 20, 0, 1);
    add(0, 0, 0, 2'b00, 3, 0, 0, 0, 3, 5, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rdIndex1 = 4'(i);
      rdIndex2 = 4'(15 - i);
      #1;
      chk("reset_rd1", i, rdData1, 0);
      chk("reset_rd2", i, rdData2, 0);
    end
    chk("reset_bad", 0, 32'(badMux_W), 0);
    chk("reset_fv", 0, 32'(fwdValid_W), 0);
    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; noop_W = vecs[i].noop; regWrtEn_W = vecs[i].wen;
      regFileMux_W = vecs[i].mux; destIndex_W = vecs[i].dest; incPC_W = vecs[i].inc;
      ALUresult_W = vecs[i].alu; MEMresult_W = vecs[i].mem;
      rdIndex1 = vecs[i].rd1; rdIndex2 = vecs[i].rd2;
      #1;
      chk("rd1", i, rdData1, vecs[i].e_rd1);
      chk("rd2", i, rdData2, vecs[i].e_rd2);
      chk("fwd_valid", i, 32'(fwdValid_W), 32'(vecs[i].e_fv));
      chk("bad_mux", i, 32'(badMux_W), 32'(vecs[i].e_bad));
      if (vecs[i].e_fv) begin
        chk("fwd_index", i, 32'(fwdIndex_W), 32'(vecs[i].dest));
        chk("fwd_data", i, fwdData_W, vecs[i].e_rd1);
      end
    end
    // Reset then 4 retiring cycles and 2 bubbles.
    @(negedge clk);
    reset = 1'b1; noop_W = 1'b0; regWrtEn_W = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      noop_W = (i >= 4);
      regWrtEn_W = (i == 1);
      destIndex_W = 4'd9; ALUresult_W = 32'd123; regFileMux_W = 2'b00;
      @(negedge clk);
    end
    noop_W = 1'b1;
    rdIndex1 = 4'd9; rdIndex2 = 4'd13;
    #1;
    chk("post_seq_rd1", 0, rdData1, 123);
    chk("post_seq_rd2", 0, rdData2, 0);
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt", 0, retireCnt_W, 4);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
